// File: rtl/player_physics.sv
// player_physics: lane-runner player state (jump/duck/lane), score, half-block ticks and collision.
module player_physics #(
  parameter int NUM_LANES         = 3,
  parameter int GRAVITY           = 3,
  parameter int JUMP_VELOCITY     = 10,
  parameter int DUCK_LIMIT        = 15,
  parameter int LOW_CLEAR         = 16,
  parameter int HALF_BLOCK_LENGTH = 32,
  parameter int SPEED             = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         new_frame,
  input  logic                         jump,
  input  logic                         duck,
  input  logic                         left,
  input  logic                         right,
  input  logic                         obstacle_valid,
  input  logic [$clog2(NUM_LANES)-1:0] obstacle_lane,
  input  logic [1:0]                   obstacle_type,
  output logic                         game_over,
  output logic [$clog2(NUM_LANES)-1:0] player_lane,
  output logic signed [15:0]           player_height,
  output logic [15:0]                  player_score,
  output logic                         airborne,
  output logic                         ducking,
  output logic                         half_block_tick
);
  localparam int LW = $clog2(NUM_LANES);
  localparam logic signed [7:0] JV = 8'(JUMP_VELOCITY);
  localparam logic signed [7:0] GR = 8'(GRAVITY);
  localparam logic signed [15:0] LC = 16'(LOW_CLEAR);
  typedef enum logic [1:0] {GROUND, AIR, DUCK, DEAD} state_t;
  state_t state, state_n;
  logic signed [7:0] vel, vel_n, v_eff;
  logic signed [15:0] height_n;
  logic signed [16:0] h_sum;
  logic [LW-1:0] lane_n;
  logic [15:0] score_n, cnt, cnt_n, hb, hb_n;
  logic [31:0] s_sum, hb_sum;
  logic pj, pl, pr, je, le, re, hit, adv, wrap, tick_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= GROUND;
      player_lane     <= LW'(NUM_LANES / 2);
      player_height   <= '0;
      vel             <= '0;
      player_score    <= '0;
      cnt             <= '0;
      hb              <= '0;
      {pj, pl, pr}    <= '0;
      half_block_tick <= 1'b0;
    end else begin
      state           <= state_n;
      player_lane     <= lane_n;
      player_height   <= height_n;
      vel             <= vel_n;
      player_score    <= score_n;
      cnt             <= cnt_n;
      hb              <= hb_n;
      half_block_tick <= tick_n;
      if (adv) {pj, pl, pr} <= {jump, left, right};
    end
  end
  // Collision looks at the registered state, so it precedes any same-cycle frame update.
  assign hit = obstacle_valid && obstacle_lane == player_lane && state != DEAD &&
               (obstacle_type == 2'd3 || (obstacle_type == 2'd2 && state != DUCK) ||
                (obstacle_type == 2'd1 && player_height < LC));
  assign adv    = new_frame && state != DEAD && !hit;
  assign je     = jump & ~pj;
  assign le     = left & ~pl;
  assign re     = right & ~pr;
  assign v_eff  = duck ? -JV : vel;
  assign h_sum  = {player_height[15], player_height} + 17'(v_eff);
  assign s_sum  = 32'(player_score) + 32'(SPEED);
  assign hb_sum = 32'(hb) + 32'(SPEED % HALF_BLOCK_LENGTH);
  assign wrap   = hb_sum >= 32'(HALF_BLOCK_LENGTH);
  always_comb begin
    state_n  = hit ? DEAD : state;
    height_n = player_height;
    vel_n    = vel;
    lane_n   = player_lane;
    score_n  = player_score;
    cnt_n    = cnt;
    hb_n     = hb;
    tick_n   = 1'b0;
    if (adv) begin
      score_n = s_sum > 32'hFFFF ? 16'hFFFF : s_sum[15:0];
      hb_n    = 16'(wrap ? hb_sum - 32'(HALF_BLOCK_LENGTH) : hb_sum);
      tick_n  = wrap;
      lane_n  = (le && !re && player_lane != '0) ? player_lane - LW'(1) :
                (re && !le && player_lane != LW'(NUM_LANES - 1)) ? player_lane + LW'(1) : player_lane;
      case (state)
        GROUND: begin
          if (duck) begin
            state_n = DUCK;
            cnt_n   = 16'd1;
          end else if (je) begin
            state_n  = AIR;
            height_n = 16'(JV);
            vel_n    = JV - GR;
          end
        end
        AIR: begin
          if (h_sum <= 17'sd0) begin
            height_n = '0;
            vel_n    = '0;
            state_n  = duck ? DUCK : GROUND;
            cnt_n    = duck ? 16'd1 : 16'd0;
          end else begin
            height_n = h_sum[15:0];
            vel_n    = v_eff - GR;
          end
        end
        DUCK: begin
          if (cnt < 16'(DUCK_LIMIT)) cnt_n = cnt + 16'd1;
          else begin
            state_n = duck ? DUCK : GROUND;
            cnt_n   = duck ? 16'd1 : 16'd0;
          end
        end
        default: ;
      endcase
    end
  end
  always_comb begin
    game_over = state == DEAD;
    airborne  = state == AIR;
    ducking   = state == DUCK;
  end
endmodule

// File: tb/tb_player_physics.sv
// tb_player_physics: directed checks of jump arc, lanes, ducking, scoring, ticks and collisions.
module tb_player_physics;
  logic clk = 1'b0, rst, new_frame, jump, duck, left, right, obstacle_valid, nf2;
  logic [1:0] obstacle_lane, obstacle_type;
  logic game_over, airborne, ducking, half_block_tick;
  logic [1:0] player_lane;
  logic signed [15:0] player_height;
  logic [15:0] player_score;
  logic s_go, s_air, s_duck, s_tick;
  logic [1:0] s_lane;
  logic signed [15:0] s_height;
  logic [15:0] s_score;
  int tests = 0, fails = 0, nframes = 0, ticks = 0, s_exp;
  int heights[8] = '{10, 17, 21, 22, 20, 15, 7, 0};
  int sat[5] = '{20000, 40000, 60000, 65535, 65535};

  always #5 clk = ~clk;

  player_physics u_dut (
    .clk(clk), .rst(rst), .new_frame(new_frame), .jump(jump), .duck(duck), .left(left),
    .right(right), .obstacle_valid(obstacle_valid), .obstacle_lane(obstacle_lane),
    .obstacle_type(obstacle_type), .game_over(game_over), .player_lane(player_lane),
    .player_height(player_height), .player_score(player_score), .airborne(airborne),
    .ducking(ducking), .half_block_tick(half_block_tick)
  );

  player_physics #(.SPEED(20000)) u_sat (
    .clk(clk), .rst(rst), .new_frame(nf2), .jump(1'b0), .duck(1'b0), .left(1'b0),
    .right(1'b0), .obstacle_valid(1'b0), .obstacle_lane(2'd0), .obstacle_type(2'd0),
    .game_over(s_go), .player_lane(s_lane), .player_height(s_height),
    .player_score(s_score), .airborne(s_air), .ducking(s_duck), .half_block_tick(s_tick)
  );

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic frame();
    @(negedge clk) new_frame = 1'b1;
    @(negedge clk) new_frame = 1'b0;
    nframes++;
    if (half_block_tick) ticks++;
  endtask

  task automatic obst(input logic [1:0] lane, input logic [1:0] kind);
    @(negedge clk) begin
      obstacle_valid = 1'b1;
      obstacle_lane  = lane;
      obstacle_type  = kind;
    end
    @(negedge clk) obstacle_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) begin
      rst = 1'b1;
      {new_frame, jump, duck, left, right, obstacle_valid, nf2} = '0;
      obstacle_lane = '0;
      obstacle_type = '0;
    end
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    nframes = 0;
    ticks = 0;
  endtask

  initial begin
    rst = 1'b1;
    {new_frame, jump, duck, left, right, obstacle_valid, nf2} = '0;
    obstacle_lane = '0;
    obstacle_type = '0;
    do_reset();
    check("rst_lane", player_lane, 1);
    check("rst_height", player_height, 0);
    check("rst_score", player_score, 0);
    check("rst_game_over", game_over, 0);
    check("rst_airborne", airborne, 0);
    check("rst_ducking", ducking, 0);
    check("rst_tick", half_block_tick, 0);

    jump = 1'b1;
    frame();
    check("jump_h0", player_height, heights[0]);
    check("jump_airborne", airborne, 1);
    jump = 1'b0;
    for (int i = 1; i < 8; i++) begin
      frame();
      check($sformatf("jump_h%0d", i), player_height, heights[i]);
    end
    check("landed_airborne", airborne, 0);
    check("score_8", player_score, 8);

    right = 1'b1;
    repeat (5) frame();
    check("right_hold_lane", player_lane, 2);
    right = 1'b0;
    frame();
    left = 1'b1;
    right = 1'b1;
    frame();
    check("both_edges_lane", player_lane, 2);
    left = 1'b0;
    right = 1'b0;
    frame();

    duck = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      jump = (i == 20);
      frame();
      check($sformatf("duck_f%0d", i), ducking, 1);
    end
    jump = 1'b0;
    check("duck_no_air", airborne, 0);
    duck = 1'b0;
    repeat (14) frame();
    check("duck_tail", ducking, 1);
    frame();
    check("duck_end", ducking, 0);

    while (nframes < 64) frame();
    check("score_64", player_score, 64);
    check("ticks_64", ticks, 2);
    @(negedge clk);
    check("tick_width", half_block_tick, 0);

    duck = 1'b1;
    frame();
    obst(2'd2, 2'd2);
    check("duck_high", game_over, 0);
    obst(2'd0, 2'd3);
    check("wall_other_lane", game_over, 0);
    obst(2'd2, 2'd0);
    check("none_same_lane", game_over, 0);
    duck = 1'b0;
    repeat (15) frame();
    check("duck_released", ducking, 0);
    obst(2'd2, 2'd2);
    check("high_standing", game_over, 1);

    do_reset();
    check("rst_dead_go", game_over, 0);
    check("rst_dead_lane", player_lane, 1);
    jump = 1'b1;
    frame();
    jump = 1'b0;
    frame();
    check("h17", player_height, 17);
    obst(2'd1, 2'd1);
    check("low_cleared", game_over, 0);
    repeat (6) frame();
    check("land2", player_height, 0);
    jump = 1'b1;
    frame();
    jump = 1'b0;
    obst(2'd0, 2'd1);
    check("low_other_lane", game_over, 0);
    obst(2'd1, 2'd1);
    check("low_hit", game_over, 1);
    s_exp = nframes;
    right = 1'b1;
    repeat (3) frame();
    check("dead_score", player_score, s_exp);
    check("dead_lane", player_lane, 1);
    check("dead_height", player_height, 10);
    check("dead_airborne", airborne, 0);

    do_reset();
    check("rst2_score", player_score, 0);
    check("rst2_height", player_height, 0);
    @(negedge clk) begin
      new_frame = 1'b1;
      obstacle_valid = 1'b1;
      obstacle_lane = 2'd1;
      obstacle_type = 2'd3;
    end
    @(negedge clk) begin
      new_frame = 1'b0;
      obstacle_valid = 1'b0;
    end
    check("wall_go", game_over, 1);
    check("wall_beats_frame", player_score, 0);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk) nf2 = 1'b1;
      @(negedge clk) nf2 = 1'b0;
      check($sformatf("sat_f%0d", i), s_score, sat[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
